// File: rtl/types.sv
// Shared types for the issue controller: register-file size, index widths,
// FSM state encoding and the issue-register payload.
package types;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W     = $clog2(NUM_REGS) + 1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } issue_state_t;

    // wr marks an entry that set its rd bit in the scoreboard
    typedef struct packed {
        logic     valid;
        logic     wr;
        reg_idx_t rd;
    } iss_entry_t;

endpackage

// File: rtl/scoreboard.sv
// Pending-writer bit vector: set on issue, cleared on writeback or squash,
// with a population count of in-flight writers.
module scoreboard
    import types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  reg_idx_t            set_idx,
    input  logic                wb_en,
    input  reg_idx_t            wb_idx,
    input  logic                sq_en,
    input  reg_idx_t            sq_idx,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    inflight_cnt
);

    logic [NUM_REGS-1:0] pending_nxt;

    // Clears first so a coincident set on the same bit wins; x0 never pends
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_idx] = 1'b0;
        end
        if (sq_en) begin
            pending_nxt[sq_idx] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_idx] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(pending[i]);
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue stage: RAW/WAW interlock against the pending scoreboard,
// single issue register, and a branch-wait state that stalls decode.
module issue_ctrl
    import types::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  reg_idx_t            rs1,
    input  reg_idx_t            rs2,
    input  reg_idx_t            rd,
    input  logic                use_rs2,
    input  logic                rd_write,
    input  logic                is_branch,
    output logic                iss_valid,
    input  logic                iss_ready,
    output reg_idx_t            iss_rd,
    input  logic                wb_valid,
    input  reg_idx_t            wb_rd,
    input  logic                br_resolve,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    inflight_cnt
);

    issue_state_t state;
    issue_state_t state_nxt;
    iss_entry_t   iss_q;
    logic         hazard;
    logic         accept;
    logic         set_en;
    logic         sq_en;

    // Hazard sees only registered pending, so writeback releases a cycle later
    assign hazard = pending[rs1] | (use_rs2 & pending[rs2]) | (rd_write & pending[rd]);
    assign accept = dec_valid & dec_ready;
    assign set_en = accept & rd_write & (rd != '0);
    assign sq_en  = flush & iss_q.valid & iss_q.wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dec_ready = 1'b0;
        if (state == RUN) begin
            dec_ready = !hazard && !flush && (!iss_q.valid || iss_ready);
        end
        case (state)
            RUN:     if (accept && is_branch) state_nxt = BR_WAIT;
            BR_WAIT: if (br_resolve || flush) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Issue register: flush beats accept, accept beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q <= '0;
        end else if (flush) begin
            iss_q.valid <= 1'b0;
        end else if (accept) begin
            iss_q <= '{valid: 1'b1, wr: set_en, rd: rd};
        end else if (iss_ready) begin
            iss_q.valid <= 1'b0;
        end
    end

    assign iss_valid = iss_q.valid;
    assign iss_rd    = iss_q.rd;

    scoreboard u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en       (set_en),
        .set_idx      (rd),
        .wb_en        (wb_valid),
        .wb_idx       (wb_rd),
        .sq_en        (sq_en),
        .sq_idx       (iss_q.rd),
        .pending      (pending),
        .inflight_cnt (inflight_cnt)
    );

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
REQ-003 dec_valid  input  1  decode presents a valid instruction.
REQ-004 dec_ready  output  1  controller accepts the decode instruction this cycle.
REQ-005 rs1, rs2, rd  input  5 each  register indices from decode.
REQ-006 use_rs2  input  1  instruction reads rs2 (OP, BRANCH); 0 for OP_IMM.
REQ-007 rd_write  input  1  instruction writes rd (decode control.rd_write).
REQ-008 is_branch  input  1  decode control.branch != BRANCH_NONE.
REQ-009 iss_valid  output  1  issue register holds a valid instruction.
REQ-010 iss_ready  input  1  execute consumes the issue register this cycle.
REQ-011 iss_rd  output  5  rd of the issue-register entry.
REQ-012 wb_valid, wb_rd  input  1, 5  writeback of a pending register completes.
REQ-013 br_resolve  input  1  execute has resolved the outstanding branch.
REQ-014 flush  input  1  squash the issue-register entry.
REQ-015 pending  output  32  scoreboard; bit n = register n has an in-flight writer.
REQ-016 inflight_cnt  output  6  population count of pending.

Function
REQ-017 hazard SHALL be (pending[rs1]) OR (use_rs2 AND pending[rs2]) OR (rd_write AND pending[rd]), evaluated on registered pending only; writeback releases a hazard one cycle after wb_valid.
REQ-018 dec_ready SHALL be 1 iff state==RUN, NOT hazard, NOT flush, and (NOT iss_valid OR iss_ready).
REQ-019 Accept = dec_valid AND dec_ready; on accept the issue register SHALL load (valid=1, rd) next edge; otherwise, if iss_ready, iss_valid SHALL clear.
REQ-020 On accept with rd_write=1 and rd!=0, pending[rd] SHALL set next edge; pending[0] SHALL always read 0.
REQ-021 wb_valid SHALL clear pending[wb_rd] next edge; writeback to a non-pending register or x0 SHALL be ignored.
REQ-022 Set and clear of the same bit in one cycle cannot arise (REQ-017 blocks WAW); if forced, set SHALL win.
REQ-023 FSM states RUN, BR_WAIT; RUN->BR_WAIT on accept with is_branch=1; BR_WAIT->RUN on br_resolve or flush; no accepts in BR_WAIT.
REQ-024 flush SHALL clear iss_valid next edge and clear pending[iss_rd] if the squashed entry set it; flush has priority over accept and iss_ready.
REQ-025 inflight_cnt SHALL equal popcount(pending) every cycle (combinational from registered pending).
REQ-026 Throughput: one instruction per cycle with no hazards and iss_ready held 1; dec->iss latency one cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force pending=0, iss_valid=0, iss_rd=0, state=RUN, hence inflight_cnt=0, dec_ready follows REQ-018 from reset state.
REQ-028 Reset mid-operation SHALL discard all in-flight tracking; subsequent writebacks of stale rd are ignored (REQ-021).

Structure
REQ-029 issue_state_t (RUN, BR_WAIT) and NUM_REGS=32 SHALL live in package types.
REQ-030 Scoreboard bit-vector, set/clear logic and popcount SHALL be sub-module scoreboard; FSM and issue register remain in issue_ctrl.

Verification
REQ-031 Reset: rst_n=0 mid-stream with pending=0x0000_0104 -> pending=0, iss_valid=0, inflight_cnt=0 immediately, without a clock edge.
REQ-032 RAW: accept add x5 (rd_write=1), then dec rs1=5 -> dec_ready=0 until cycle after wb_valid,wb_rd=5; pending[5] 1->0, inflight_cnt 1->0.
REQ-033 x0/OP_IMM: accept rd=0 rd_write=1 -> pending stays 0; OP_IMM with rs2=7 pending, use_rs2=0 -> accepted.
REQ-034 Backpressure: iss_ready=0 two cycles with iss_valid=1 -> dec_ready=0, issue register stable; iss_ready=1 -> back-to-back accept same cycle.
REQ-035 Branch: accept is_branch=1 -> state BR_WAIT, dec_ready=0 for three cycles; br_resolve pulse -> RUN, accept next cycle.
REQ-036 Flush: issue register holds rd=9 writer, flush=1 with dec_valid=1 -> iss_valid=0, pending[9]=0, no accept that cycle.
